// File: rtl/thread_scheduler.sv
// Thread table and round-robin issuer for the multi-CPU core.
// Holds up to PROC_QUANTITY active {data, addr} threads plus a PEND_DEPTH fork queue.
// Optional macro THRD_PRIO_EN: issue only among valid slots of the highest 2-bit priority.

package thread_scheduler_pkg;
  localparam logic [7:0] CTL_CPU_LOOP    = 8'h01;
  localparam logic [7:0] CTL_CPU_CMD     = 8'h02;
  localparam logic [7:0] CPU_R_FORK_DONE = 8'h10;
  localparam logic [7:0] CPU_R_STOP_DONE = 8'h11;

  localparam logic [3:0] THREAD_CMD_NOP            = 4'h0;
  localparam logic [3:0] THREAD_CMD_RUN            = 4'h1;
  localparam logic [3:0] THREAD_CMD_STOP           = 4'h2;
  localparam logic [3:0] THREAD_CMD_GET_NEXT_STATE = 4'h3;

  localparam logic [1:0] RSLT_REFUSED   = 2'd0;
  localparam logic [1:0] RSLT_OK        = 2'd1;
  localparam logic [1:0] RSLT_NOT_FOUND = 2'd2;
endpackage

module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int unsigned PROC_QUANTITY = 8,
  parameter int unsigned PEND_DEPTH    = 4,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 32,
  localparam int unsigned CNT_W        = $clog2(PROC_QUANTITY + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_oe,
  input  logic [7:0]        ctl_state,
  input  logic [7:0]        cpu_msg_in,
  input  logic              cpu_q,
  input  logic [3:0]        thrd_cmd,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] next_proc,
  output logic [DATA_W-1:0] next_data,
  output logic              sched_valid,
  output logic [1:0]        thrd_rslt,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  active_cnt
);

  localparam int unsigned SLOT_W = $clog2(PROC_QUANTITY);
  localparam int unsigned SUM_W  = SLOT_W + 1;
  localparam int unsigned QPTR_W = $clog2(PEND_DEPTH);
  localparam int unsigned QCNT_W = $clog2(PEND_DEPTH + 1);

  // Active table
  logic [PROC_QUANTITY-1:0] slot_valid;
  logic [ADDR_W-1:0]        slot_addr [PROC_QUANTITY];
  logic [DATA_W-1:0]        slot_data [PROC_QUANTITY];
  logic [SLOT_W-1:0]        rr_ptr;

  // Fork queue
  logic [ADDR_W-1:0] q_addr [PEND_DEPTH];
  logic [DATA_W-1:0] q_data [PEND_DEPTH];
  logic [QPTR_W-1:0] q_head;
  logic [QPTR_W-1:0] q_tail;
  logic [QCNT_W-1:0] q_cnt;

  logic              ready;
  logic [DATA_W-1:0] data_r;

  // Decode and search results
  logic                     in_loop, in_cmd, get_next, ready_eff;
  logic                     q_empty, q_full;
  logic                     free_found;
  logic [SLOT_W-1:0]        free_idx;
  logic [PROC_QUANTITY-1:0] elig;
  logic                     rr_found;
  logic [SLOT_W-1:0]        rr_idx;
  logic [SUM_W-1:0]         cand;
  logic                     stop_hit;
  logic [SLOT_W-1:0]        stop_idx;
  logic                     do_promote, do_rr, is_run, is_stop;
  logic [ADDR_W-1:0]        issue_addr;
  logic [DATA_W-1:0]        issue_data;

  assign in_loop   = (ctl_state == CTL_CPU_LOOP);
  assign in_cmd    = (ctl_state == CTL_CPU_CMD);
  assign get_next  = (thrd_cmd == THREAD_CMD_GET_NEXT_STATE);
  assign ready_eff = ready | get_next;
  assign is_run    = in_cmd && (thrd_cmd == THREAD_CMD_RUN);
  assign is_stop   = in_cmd && (thrd_cmd == THREAD_CMD_STOP);
  assign q_empty   = (q_cnt == '0);
  assign q_full    = (q_cnt == QCNT_W'(PEND_DEPTH));

  // Lowest-index free slot
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = PROC_QUANTITY - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

`ifdef THRD_PRIO_EN
  logic [1:0] slot_prio [PROC_QUANTITY];
  logic [1:0] top_prio;

  // Restrict round-robin candidates to the highest priority present
  always_comb begin
    top_prio = '0;
    elig     = '0;
    for (int i = 0; i < PROC_QUANTITY; i++) begin
      if (slot_valid[i] && (slot_prio[i] > top_prio)) top_prio = slot_prio[i];
    end
    for (int i = 0; i < PROC_QUANTITY; i++) begin
      elig[i] = slot_valid[i] && (slot_prio[i] == top_prio);
    end
  end

  // Priority captured from data[1:0] when a thread is promoted
  always_ff @(posedge clk) begin
    if (rst && clk_oe && do_promote) slot_prio[free_idx] <= q_data[q_head][1:0];
  end
`else
  assign elig = slot_valid;
`endif

  // Cyclic search from rr_ptr+1; rr_ptr itself is visited last
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = rr_ptr;
    cand     = '0;
    for (int k = PROC_QUANTITY; k >= 1; k--) begin
      cand = {1'b0, rr_ptr} + SUM_W'(k);
      if (cand >= SUM_W'(PROC_QUANTITY)) cand = cand - SUM_W'(PROC_QUANTITY);
      if (elig[cand[SLOT_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[SLOT_W-1:0];
      end
    end
  end

  // Lowest-index valid slot whose address matches the stop target
  always_comb begin
    stop_hit = 1'b0;
    stop_idx = '0;
    for (int i = PROC_QUANTITY - 1; i >= 0; i--) begin
      if (slot_valid[i] && (slot_addr[i] == addr_in)) begin
        stop_hit = 1'b1;
        stop_idx = SLOT_W'(i);
      end
    end
  end

  // Issue selection: promotion from the queue beats round-robin
  always_comb begin
    do_promote = in_loop && ready_eff && !q_empty && free_found;
    do_rr      = in_loop && ready_eff && !do_promote && rr_found;
    issue_addr = do_promote ? q_addr[q_head] : slot_addr[rr_idx];
    issue_data = do_promote ? q_data[q_head] : slot_data[rr_idx];
  end

  // Slot payload storage, no reset needed behind the valid bits
  always_ff @(posedge clk) begin
    if (rst && clk_oe && do_promote) begin
      slot_addr[free_idx] <= q_addr[q_head];
      slot_data[free_idx] <= q_data[q_head];
    end
  end

  // Queue payload storage; reset plants the root thread at entry 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_addr[0] <= '0;
      q_data[0] <= '0;
    end else if (clk_oe && is_run && !q_full) begin
      q_addr[q_tail] <= addr_in;
      q_data[q_tail] <= data_in;
    end
  end

  // Control state, issue outputs and command results
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_valid  <= '0;
      rr_ptr      <= '0;
      q_head      <= '0;
      q_tail      <= QPTR_W'(1);
      q_cnt       <= QCNT_W'(1);
      ready       <= 1'b1;
      data_r      <= '0;
      next_proc   <= '0;
      next_data   <= '0;
      sched_valid <= 1'b0;
      thrd_rslt   <= RSLT_REFUSED;
      active_cnt  <= '0;
    end else if (!clk_oe) begin
      sched_valid <= 1'b0;
    end else begin
      sched_valid <= 1'b0;
      ready       <= ready_eff;

      if (do_promote) begin
        slot_valid[free_idx] <= 1'b1;
        q_head               <= q_head + QPTR_W'(1);
        q_cnt                <= q_cnt - QCNT_W'(1);
        active_cnt           <= active_cnt + CNT_W'(1);
        rr_ptr               <= free_idx;
      end else if (do_rr) begin
        rr_ptr <= rr_idx;
      end

      if (do_promote || do_rr) begin
        next_proc   <= issue_addr;
        next_data   <= issue_data;
        sched_valid <= 1'b1;
        ready       <= 1'b0;
      end

      if (is_run) begin
        if (!q_full) begin
          q_tail    <= q_tail + QPTR_W'(1);
          q_cnt     <= q_cnt + QCNT_W'(1);
          thrd_rslt <= RSLT_OK;
          data_r    <= '1;
        end else begin
          thrd_rslt <= RSLT_REFUSED;
          data_r    <= '0;
        end
      end

      if (is_stop) begin
        if (stop_hit) begin
          slot_valid[stop_idx] <= 1'b0;
          active_cnt           <= active_cnt - CNT_W'(1);
          thrd_rslt            <= RSLT_OK;
          data_r               <= '1;
        end else begin
          thrd_rslt <= RSLT_NOT_FOUND;
          data_r    <= '0;
        end
      end
    end
  end

  // Result word is driven only when a done message or a bus query asks for it
  always_comb begin
    data_out = '0;
    if ((in_cmd && ((cpu_msg_in == CPU_R_FORK_DONE) || (cpu_msg_in == CPU_R_STOP_DONE))) || cpu_q)
      data_out = data_r;
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: behavioural model feeds expectation queues.
module tb_thread_scheduler;
  import thread_scheduler_pkg::*;

  localparam int P  = 8;
  localparam int PD = 4;

  logic        clk = 1'b0;
  logic        rst, clk_oe, cpu_q;
  logic [7:0]  ctl_state, cpu_msg_in;
  logic [3:0]  thrd_cmd;
  logic [31:0] data_in, addr_in;
  logic [31:0] next_proc, next_data, data_out;
  logic        sched_valid;
  logic [1:0]  thrd_rslt;
  logic [3:0]  active_cnt;

  always #5 clk = ~clk;

  thread_scheduler #(.PROC_QUANTITY(P), .PEND_DEPTH(PD), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe), .ctl_state(ctl_state), .cpu_msg_in(cpu_msg_in),
    .cpu_q(cpu_q), .thrd_cmd(thrd_cmd), .data_in(data_in), .addr_in(addr_in),
    .next_proc(next_proc), .next_data(next_data), .sched_valid(sched_valid),
    .thrd_rslt(thrd_rslt), .data_out(data_out), .active_cnt(active_cnt)
  );

  typedef struct { bit v; logic [31:0] p; logic [31:0] d; int cnt; logic [31:0] dout; } issue_t;
  typedef struct { logic [1:0] r; logic [31:0] dout; int cnt; } cmd_t;

  issue_t issue_q[$];
  cmd_t   cmd_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          m_valid [P];
  logic [31:0] m_addr  [P];
  logic [31:0] m_data  [P];
  logic [63:0] m_q[$];
  int          m_rr, m_cnt;
  bit          m_ready;
  logic [1:0]  m_rslt;
  logic [31:0] m_data_r, m_np, m_nd;

  function automatic void model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_q = {};
    m_q.push_back(64'h0);
    m_rr = 0; m_cnt = 0; m_ready = 1'b1; m_rslt = 2'd0;
    m_data_r = '0; m_np = '0; m_nd = '0;
    issue_q = {}; cmd_q = {};
  endfunction

  function automatic bit prio_ok(input int j);
`ifdef THRD_PRIO_EN
    int top = 0;
    for (int i = 0; i < P; i++) if (m_valid[i] && int'(m_data[i][1:0]) > top) top = int'(m_data[i][1:0]);
    return int'(m_data[j][1:0]) == top;
`else
    return (j >= 0);
`endif
  endfunction

  function automatic void model_loop(input bit gns, input bit q);
    bit rdy = m_ready | gns;
    bit issued = 1'b0;
    int f = -1;
    logic [63:0] e;
    if (rdy) begin
      for (int i = 0; i < P; i++) if (!m_valid[i] && f < 0) f = i;
      if (m_q.size() != 0 && f >= 0) begin
        e = m_q.pop_front();
        m_valid[f] = 1'b1; m_data[f] = e[63:32]; m_addr[f] = e[31:0];
        m_rr = f; m_cnt++; issued = 1'b1;
        m_np = m_addr[f]; m_nd = m_data[f];
      end else begin
        for (int k = 1; k <= P && !issued; k++) begin
          int j = (m_rr + k) % P;
          if (m_valid[j] && prio_ok(j)) begin
            m_rr = j; issued = 1'b1; m_np = m_addr[j]; m_nd = m_data[j];
          end
        end
      end
    end
    m_ready = issued ? 1'b0 : rdy;
    issue_q.push_back('{issued, m_np, m_nd, m_cnt, q ? m_data_r : 32'h0});
  endfunction

  function automatic void model_cmd(input logic [3:0] cmd, input logic [31:0] a,
                                    input logic [31:0] d, input logic [7:0] msg);
    bit hit = 1'b0;
    if (cmd == THREAD_CMD_GET_NEXT_STATE) m_ready = 1'b1;
    if (cmd == THREAD_CMD_RUN) begin
      if (m_q.size() < PD) begin m_q.push_back({d, a}); m_rslt = 2'd1; m_data_r = '1; end
      else begin m_rslt = 2'd0; m_data_r = '0; end
    end
    if (cmd == THREAD_CMD_STOP) begin
      for (int i = 0; i < P; i++) begin
        if (!hit && m_valid[i] && m_addr[i] == a) begin m_valid[i] = 1'b0; hit = 1'b1; m_cnt--; end
      end
      m_rslt   = hit ? 2'd1 : 2'd2;
      m_data_r = hit ? '1 : '0;
    end
    cmd_q.push_back('{m_rslt, (msg == CPU_R_FORK_DONE || msg == CPU_R_STOP_DONE) ? m_data_r : 32'h0, m_cnt});
  endfunction

  task automatic drive_loop(input bit gns, input bit q);
    @(negedge clk);
    clk_oe = 1'b1; ctl_state = CTL_CPU_LOOP; cpu_msg_in = 8'h0; cpu_q = q;
    thrd_cmd = gns ? THREAD_CMD_GET_NEXT_STATE : THREAD_CMD_NOP;
    model_loop(gns, q);
    @(posedge clk); #1;
  endtask

  task automatic drive_cmd(input logic [3:0] cmd, input logic [31:0] a,
                           input logic [31:0] d, input logic [7:0] msg);
    @(negedge clk);
    clk_oe = 1'b1; ctl_state = CTL_CPU_CMD; cpu_msg_in = msg; cpu_q = 1'b0;
    thrd_cmd = cmd; addr_in = a; data_in = d;
    model_cmd(cmd, a, d, msg);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    issue_t e;
    @(negedge clk);
    rst = 1'b0; clk_oe = 1'b0; cpu_q = 1'b1;
    ctl_state = CTL_CPU_LOOP; thrd_cmd = THREAD_CMD_GET_NEXT_STATE;
    @(posedge clk); #1;
    model_reset();
    tests++;
    if (next_proc !== 32'h0 || next_data !== 32'h0 || sched_valid !== 1'b0 ||
        thrd_rslt !== 2'd0 || active_cnt !== 4'd0 || data_out !== 32'h0) begin
      fails++;
      $display("FAIL reset: proc=%h data=%h sv=%b rslt=%0d cnt=%0d dout=%h, want all zero",
               next_proc, next_data, sched_valid, thrd_rslt, active_cnt, data_out);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_loop(1'b0, 1'b0);
      e = issue_q.pop_front();
      tests++;
      if (sched_valid !== e.v || next_proc !== e.p || next_data !== e.d || active_cnt !== 4'(e.cnt)) begin
        fails++;
        $display("FAIL root_issue[%0d]: sv=%b proc=%h data=%h cnt=%0d, want sv=%b proc=%h data=%h cnt=%0d",
                 i, sched_valid, next_proc, next_data, active_cnt, e.v, e.p, e.d, e.cnt);
      end
    end
  endtask

  task automatic test_fork();
    cmd_t c; issue_t e;
    drive_cmd(THREAD_CMD_RUN, 32'h100, 32'h5, CPU_R_FORK_DONE);
    c = cmd_q.pop_front();
    tests++;
    if (thrd_rslt !== c.r || data_out !== c.dout || active_cnt !== 4'(c.cnt) || data_out !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL fork_cmd: rslt=%0d dout=%h cnt=%0d, want rslt=%0d dout=%h cnt=%0d",
               thrd_rslt, data_out, active_cnt, c.r, c.dout, c.cnt);
    end
    drive_loop(1'b1, 1'b0);
    e = issue_q.pop_front();
    tests++;
    if (sched_valid !== e.v || next_proc !== e.p || next_data !== e.d ||
        active_cnt !== 4'(e.cnt) || next_proc !== 32'h100) begin
      fails++;
      $display("FAIL fork_issue: sv=%b proc=%h data=%h cnt=%0d, want sv=%b proc=%h data=%h cnt=%0d",
               sched_valid, next_proc, next_data, active_cnt, e.v, e.p, e.d, e.cnt);
    end
  endtask

  task automatic test_back_to_back();
    cmd_t c; issue_t e;
    drive_cmd(THREAD_CMD_RUN, 32'h200, 32'h9, CPU_R_FORK_DONE);
    c = cmd_q.pop_front();
    tests++;
    if (thrd_rslt !== c.r || data_out !== c.dout) begin
      fails++;
      $display("FAIL rr_fork: rslt=%0d dout=%h, want rslt=%0d dout=%h", thrd_rslt, data_out, c.r, c.dout);
    end
    for (int i = 0; i < 7; i++) begin
      drive_loop(i < 6, 1'b0);
      e = issue_q.pop_front();
      tests++;
      if (sched_valid !== e.v || next_proc !== e.p || next_data !== e.d || active_cnt !== 4'(e.cnt)) begin
        fails++;
        $display("FAIL rr_issue[%0d]: sv=%b proc=%h data=%h cnt=%0d, want sv=%b proc=%h data=%h cnt=%0d",
                 i, sched_valid, next_proc, next_data, active_cnt, e.v, e.p, e.d, e.cnt);
      end
    end
  endtask

  task automatic test_stop();
    cmd_t c; issue_t e;
    logic [31:0] tgt [2];
    tgt[0] = 32'h100; tgt[1] = 32'h999;
    for (int t = 0; t < 2; t++) begin
      drive_cmd(THREAD_CMD_STOP, tgt[t], 32'h0, CPU_R_STOP_DONE);
      c = cmd_q.pop_front();
      tests++;
      if (thrd_rslt !== c.r || data_out !== c.dout || active_cnt !== 4'(c.cnt)) begin
        fails++;
        $display("FAIL stop_%h: rslt=%0d dout=%h cnt=%0d, want rslt=%0d dout=%h cnt=%0d",
                 tgt[t], thrd_rslt, data_out, active_cnt, c.r, c.dout, c.cnt);
      end
      for (int i = 0; i < 4 && t == 0; i++) begin
        drive_loop(1'b1, 1'b0);
        e = issue_q.pop_front();
        tests++;
        if (sched_valid !== e.v || next_proc !== e.p || next_data !== e.d || next_proc === 32'h100) begin
          fails++;
          $display("FAIL stop_issue[%0d]: sv=%b proc=%h data=%h, want sv=%b proc=%h data=%h",
                   i, sched_valid, next_proc, next_data, e.v, e.p, e.d);
        end
      end
    end
  endtask

  task automatic test_queue_full();
    cmd_t c;
    for (int i = 0; i < 6; i++) begin
      drive_cmd(i < 5 ? THREAD_CMD_RUN : THREAD_CMD_NOP, 32'h300 + 32'(i) * 32'h100,
                32'h10 + 32'(i), CPU_R_FORK_DONE);
      c = cmd_q.pop_front();
      tests++;
      if (thrd_rslt !== c.r || data_out !== c.dout || sched_valid !== 1'b0) begin
        fails++;
        $display("FAIL qfull_run[%0d]: rslt=%0d dout=%h sv=%b, want rslt=%0d dout=%h sv=0",
                 i, thrd_rslt, data_out, sched_valid, c.r, c.dout);
      end
    end
  endtask

  task automatic test_full_table();
    cmd_t c; issue_t e;
    // op code: 0 = loop with get-next, 1 = run, 2 = stop
    int          op   [16] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 2, 0};
    logic [31:0] addr [16] = '{0, 0, 0, 0, 32'h700, 32'h800, 0, 0, 32'h900, 0,
                               32'hA00, 32'hB00, 32'hC00, 32'hD00, 32'h400, 0};
    for (int i = 0; i < 16; i++) begin
      if (op[i] == 0) begin
        drive_loop(1'b1, 1'b0);
        e = issue_q.pop_front();
        tests++;
        if (sched_valid !== e.v || next_proc !== e.p || next_data !== e.d ||
            active_cnt !== 4'(e.cnt) || (i == 15 && next_proc !== 32'h900)) begin
          fails++;
          $display("FAIL full_issue[%0d]: sv=%b proc=%h data=%h cnt=%0d, want sv=%b proc=%h data=%h cnt=%0d",
                   i, sched_valid, next_proc, next_data, active_cnt, e.v, e.p, e.d, e.cnt);
        end
      end else begin
        drive_cmd(op[i] == 1 ? THREAD_CMD_RUN : THREAD_CMD_STOP, addr[i], addr[i] >> 4,
                  op[i] == 1 ? CPU_R_FORK_DONE : CPU_R_STOP_DONE);
        c = cmd_q.pop_front();
        tests++;
        if (thrd_rslt !== c.r || data_out !== c.dout || active_cnt !== 4'(c.cnt)) begin
          fails++;
          $display("FAIL full_cmd[%0d]: rslt=%0d dout=%h cnt=%0d, want rslt=%0d dout=%h cnt=%0d",
                   i, thrd_rslt, data_out, active_cnt, c.r, c.dout, c.cnt);
        end
      end
    end
  endtask

  task automatic test_clk_oe();
    issue_t e;
    logic [1:0] r0;
    r0 = thrd_rslt;
    @(negedge clk);
    clk_oe = 1'b0; ctl_state = CTL_CPU_CMD; thrd_cmd = THREAD_CMD_STOP; addr_in = 32'h0;
    @(negedge clk);
    ctl_state = CTL_CPU_LOOP; thrd_cmd = THREAD_CMD_GET_NEXT_STATE;
    @(posedge clk); #1;
    tests++;
    if (sched_valid !== 1'b0 || next_proc !== m_np || active_cnt !== 4'(m_cnt) || thrd_rslt !== r0) begin
      fails++;
      $display("FAIL clk_oe_hold: sv=%b proc=%h cnt=%0d rslt=%0d, want sv=0 proc=%h cnt=%0d rslt=%0d",
               sched_valid, next_proc, active_cnt, thrd_rslt, m_np, m_cnt, r0);
    end
    // get-next under a disabled clock must not have armed ready; cpu_q exposes data_r
    drive_loop(1'b0, 1'b1);
    e = issue_q.pop_front();
    tests++;
    if (sched_valid !== e.v || next_proc !== e.p || data_out !== e.dout) begin
      fails++;
      $display("FAIL clk_oe_after: sv=%b proc=%h dout=%h, want sv=%b proc=%h dout=%h",
               sched_valid, next_proc, data_out, e.v, e.p, e.dout);
    end
  endtask

  task automatic test_reset_mid();
    issue_t e;
    @(negedge clk);
    rst = 1'b0; ctl_state = CTL_CPU_CMD; thrd_cmd = THREAD_CMD_RUN; addr_in = 32'hE00; cpu_q = 1'b1;
    @(posedge clk); #1;
    model_reset();
    tests++;
    if (active_cnt !== 4'd0 || thrd_rslt !== 2'd0 || next_proc !== 32'h0 || data_out !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid: cnt=%0d rslt=%0d proc=%h dout=%h, want all zero",
               active_cnt, thrd_rslt, next_proc, data_out);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_loop(1'b1, 1'b0);
      e = issue_q.pop_front();
      tests++;
      if (sched_valid !== e.v || next_proc !== e.p || active_cnt !== 4'(e.cnt) || next_proc !== 32'h0) begin
        fails++;
        $display("FAIL reset_mid_issue[%0d]: sv=%b proc=%h cnt=%0d, want sv=%b proc=%h cnt=%0d",
                 i, sched_valid, next_proc, active_cnt, e.v, e.p, e.cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b0; clk_oe = 1'b1; cpu_q = 1'b0; ctl_state = 8'h0; cpu_msg_in = 8'h0;
    thrd_cmd = THREAD_CMD_NOP; data_in = '0; addr_in = '0;
    model_reset();
    test_reset();
    test_fork();
    test_back_to_back();
    test_stop();
    test_queue_full();
    test_full_table();
    test_clk_oe();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
Parametrised next-generation thread table for the multi-CPU core. It holds up to PROC_QUANTITY active threads, each an {data, addr} pair, plus a PEND_DEPTH-deep fork queue. It serves THREAD_CMD_RUN (fork) and THREAD_CMD_STOP (kill by address) during CTL_CPU_CMD. During CTL_CPU_LOOP it issues the next thread to run, round-robin.

Parameters:
PROC_QUANTITY, 8, active-table slots (2..64)
PEND_DEPTH, 4, fork-queue entries (power of 2, >=2)
DATA_W, 32, thread data word width (`DATA_SIZE)
ADDR_W, 32, thread entry address width (`ADDR_SIZE)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
clk_oe  in  1  clock enable; no state change when 0 (reset excepted)
ctl_state  in  8  controller state (`CTL_CPU_LOOP, `CTL_CPU_CMD)
cpu_msg_in  in  8  inter-CPU message
cpu_q  in  1  bus query; forces data_out drive
thrd_cmd  in  4  `THREAD_CMD_RUN / _STOP / _GET_NEXT_STATE
data_in  in  DATA_W  fork data
addr_in  in  ADDR_W  fork/stop address
next_proc  out  ADDR_W  address of issued thread
next_data  out  DATA_W  data of issued thread
sched_valid  out  1  1-cycle pulse when next_proc/next_data update
thrd_rslt  out  2  0 = refused, 1 = ok, 2 = stop target not found
data_out  out  DATA_W  command result word
active_cnt  out  clog2(PROC_QUANTITY+1)  valid slots

Behaviour:
- All updates occur on posedge clk.
- Reset: if rst==0 at posedge, regardless of clk_oe:
  - clear all slot valid bits; clear rr_ptr, data_r, next_proc, next_data, sched_valid, thrd_rslt and active_cnt to 0.
  - set ready=1.
  - load the fork queue with exactly one entry {0,0}, the root thread.
  - Reset mid-operation discards everything, including pending forks.
- clk_oe==0: hold all state; sched_valid forced 0.
- Ready flag:
  - thrd_cmd==`THREAD_CMD_GET_NEXT_STATE sets ready=1 in any ctl_state.
  - This is evaluated before the state case in the same cycle, so a LOOP issue can follow in that same edge.
- CTL_CPU_LOOP with ready==1, one issue per cycle at most, in priority order:
  1. Queue non-empty and a free slot exists: pop queue head into the lowest-index free slot; output it; rr_ptr = that slot.
  2. Otherwise search valid slots cyclically from rr_ptr+1 (wrap at PROC_QUANTITY-1 -> 0, rr_ptr itself last); output the first found; rr_ptr = it.
  3. Otherwise (no valid slot): hold next_proc/next_data, ready stays 1, sched_valid=0.
  - On issue: sched_valid=1 for one cycle, ready=0.
- CTL_CPU_CMD, RUN:
  - Queue not full: push {data_in, addr_in}; thrd_rslt=1; data_r=all-ones.
  - Queue full: thrd_rslt=0; data_r=0; no push.
- CTL_CPU_CMD, STOP:
  - Parallel-compare addr_in with addr of every valid slot; clear the lowest-index match only.
  - Match: thrd_rslt=1; data_r=all-ones.
  - No match: thrd_rslt=2; data_r=0.
  - Queue entries are not searched.
  - Stopping the currently issued thread is legal; the next issue skips it.
- Other commands: no change; thrd_rslt holds.
- Fork and stop only occur in CMD and issue only in LOOP, so they never coincide.
- data_out = data_r when (ctl_state==`CTL_CPU_CMD and cpu_msg_in is `CPU_R_FORK_DONE or `CPU_R_STOP_DONE) or cpu_q==1; else 0. Combinational.
- active_cnt is registered and updated on pop (+1) and on stop hit (-1).
- Latency: command result visible the cycle after the command edge.

Optional Feature:
THRD_PRIO_EN:
- Defined: each slot stores a 2-bit priority = data[1:0] at promotion. Round-robin step 2 considers only valid slots of the highest present priority (3 highest). rr_ptr is shared across priorities.
- Undefined: pure round-robin; data[1:0] is ignored by scheduling and no priority storage is synthesised.

Test Plan:
- Reset (rst=0 one cycle), then LOOP with ready -> next_proc=0, next_data=0, sched_valid=1, active_cnt=1.
- RUN addr 0x100, data 0x5; GET_NEXT_STATE; LOOP -> thrd_rslt=1, data_out=0xFFFFFFFF under FORK_DONE; then next_proc=0x100 in slot 1, active_cnt=2.
- Five RUNs with no LOOP and PEND_DEPTH=4 (queue initially empty after root pop) -> first four thrd_rslt=1, fifth thrd_rslt=0 with data_out=0.
- Three threads 0x0/0x100/0x200; repeated GET_NEXT_STATE+LOOP -> issue order 0x100, 0x200, 0x0, 0x100 (wrap).
- STOP 0x100 -> thrd_rslt=1, active_cnt=2, 0x100 never issued again; STOP 0x999 -> thrd_rslt=2, data_out=0.
- Full table of 8 with 1 queued, RUN refused only when queue full; STOP one slot then LOOP -> queued thread promoted into the freed slot. With THRD_PRIO_EN: slot data[1:0]=3 issued every time while present.
